ram_bank: RTL
=============

# ram_bank

Parametrised, byte-lane-masked, single-port synchronous RAM for the PDP-11 core's on-chip memory. It generalises the fixed 16-bit / 2 KB RAM in three ways: configurable word width and depth, a request/ready handshake with a read-valid strobe, and an optional hardware clear sequence after reset. It sits between the CPU memory bus and the block RAM and infers BlockRAM on iCE40 via a single registered read/write process per lane.

## Interface
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8; LANES = DATA_WIDTH/8.
- ADDR_WIDTH, 12: byte address width; word index = address[ADDR_WIDTH-1:log2(LANES)], DEPTH = 2^(ADDR_WIDTH-log2(LANES)) words.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting requests; 0 = contents undefined, ready immediately.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_WIDTH  byte address; low log2(LANES) bits ignored.
- data_in  in  DATA_WIDTH  write data.
- write_mask  in  LANES  active-low per-byte-lane write enable (bit n=0 writes lane n).
- write_enable  in  1  1 = write request, 0 = read request.
- request  in  1  request strobe; accepted on a cycle with request=1 and ready=1.
- ready  out  1  block accepts a request this cycle.
- data_out  out  DATA_WIDTH  registered read data; holds last read value.
- data_valid  out  1  one-cycle pulse: data_out carries the result of the read accepted on the previous cycle.
- busy  out  1  clear sequence in progress.

## Operation
- States: CLEAR, IDLE.
- Reset (async): state = CLEAR if CLEAR_ON_RESET else IDLE; clear counter = 0; data_out = 0; data_valid = 0; ready = 0 in CLEAR, 1 in IDLE; busy = 1 in CLEAR, 0 in IDLE.
- CLEAR: each cycle writes 0 to all lanes of word[counter], counter increments; after word DEPTH-1 is written, next state IDLE. Takes exactly DEPTH cycles. ready=0, requests ignored (not queued), data_valid stays 0.
- IDLE, accepted write: lanes with write_mask[n]=0 take data_in[8n+7:8n]; other lanes unchanged; data_out and data_valid unaffected. Mask all-ones is accepted as a no-op.
- IDLE, accepted read: on the next edge data_out = word[index], data_valid = 1 for one cycle. write_mask ignored on reads.
- Back-to-back requests: one per cycle, any mix of reads and writes; ready stays 1 in IDLE.
- Read following a write to the same word on the next cycle returns the newly written data. There is no same-cycle read/write; the port is single-port.
- Reset asserted mid-clear restarts the clear from word 0. Reset mid-read suppresses the pending data_valid.

## Timing
- Read latency is 1 cycle from the accepting edge to data_valid/data_out.
- Write takes effect at the accepting edge.
- ready is a function of state only (registered); no combinational path from request to ready.
- The clear sequence takes DEPTH cycles; first request accepted on cycle DEPTH after reset release (counting from 0).

## Structure
- Shared package: none required; lane count and word-index width are derived as localparams.
- Sub-module: none required. Storage is one 8-bit array per lane, generated by a generate-for over LANES, each lane written in the same clocked process as its read so BlockRAM inference holds.

## Test plan
- Clear: CLEAR_ON_RESET=1, DATA_WIDTH=16, ADDR_WIDTH=12. After reset, busy=1 and ready=0 for 2048 cycles, then ready=1. A read of address 0x7FE returns 0x0000 with data_valid one cycle later.
- Byte masks: write 0xA55A to 0x010 mask 2'b00, then 0x1234 mask 2'b10. A read of 0x010 returns 0xA534. A read of 0x011 returns the same (bit 0 ignored).
- Wide config: DATA_WIDTH=32. Write 0xDEADBEEF mask 4'b0101 over 0x00000000. A read returns 0xDE00BE00.
- Back-to-back: W 0x020=0x1111, R 0x020, W 0x020=0x2222, R 0x020 on consecutive cycles. data_valid pulses on cycles 2 and 4 with 0x1111 and 0x2222.
- Request during clear: a request pulse while busy=1 is ignored; memory is unchanged and no data_valid appears.
- Reset mid-clear: assert reset at counter=100. busy stays 1 and the clear restarts, totalling 2048 cycles after release. A pending read's data_valid is suppressed when reset is asserted the cycle after acceptance.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// rtl/ram_bank_pkg.sv - shared types and helpers for the ram_bank memory block
//
// Purpose: controller state encoding and the lane-count helper used when
// splitting a byte address into a word index.
// Ports: none (package).
package ram_bank_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Number of low address bits that select a byte inside one word.
  function automatic int unsigned lane_bits(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/ram_bank_lane.sv
// rtl/ram_bank_lane.sv - one 8-bit byte lane of the ram_bank storage
//
// Purpose: a single byte-wide synchronous RAM with one registered read
// port and one write port sharing the address. Write and read live in the
// same clocked process with no reset so the array maps onto BlockRAM.
// Ports:
//   clk_i    rising-edge clock
//   we_i     write this lane at addr_i
//   re_i     capture mem[addr_i] into the read register
//   addr_i   word index
//   wdata_i  write byte
//   rdata_o  registered read byte; holds until the next read
module ram_bank_lane #(
  parameter int unsigned IW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [IW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**IW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - byte-lane-masked single-port synchronous RAM with clear
//
// Purpose: on-chip CPU memory. Accepts one read or write per cycle through a
// request/ready handshake, returns read data one cycle later with a
// data_valid strobe, and optionally zeroes every word after reset.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   address       byte address; low lane-select bits ignored
//   data_in       write data
//   write_mask    active-low per-lane write enable
//   write_enable  1 = write request, 0 = read request
//   request       request strobe, accepted when ready is high
//   ready         block accepts a request this cycle
//   data_out      read data of the most recent read (0 after reset)
//   data_valid    one-cycle pulse for the read accepted on the previous cycle
//   busy          clear sequence in progress
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] write_mask,
  input  logic                    write_enable,
  input  logic                    request,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    busy
);

  localparam int unsigned LANES = DATA_WIDTH / BYTE_W;
  localparam int unsigned LB    = lane_bits(LANES);
  localparam int unsigned IW    = ADDR_WIDTH - LB;
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e          state_q, state_d;
  logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            data_valid_q, data_valid_d;
  logic            rd_seen_q, rd_seen_d;

  logic            clearing;
  logic            accept;
  logic            wr_acc;
  logic            rd_acc;
  logic [IW-1:0]   word_idx;
  logic [IW-1:0]   mem_addr;
  logic [LANES-1:0] lane_we;
  logic [DATA_WIDTH-1:0] rdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic: the counter walks every word once, leaving on the
  // cycle that writes the last word (counter all ones).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    clearing = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy     = 1'b1;
        clearing = 1'b1;
      end
      ST_IDLE: begin
        ready = 1'b1;
      end
    endcase
  end

  assign accept   = request & ready;
  assign wr_acc   = accept & write_enable;
  assign rd_acc   = accept & ~write_enable;
  assign word_idx = address[ADDR_WIDTH-1:LB];
  assign mem_addr = clearing ? clr_cnt_q : word_idx;

  // Read strobe and "a read has happened" flag. The lane read registers
  // carry no reset, so data_out is forced to zero until the first read.
  assign data_valid_d = rd_acc;
  assign rd_seen_d    = rd_seen_q | rd_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_valid_q <= 1'b0;
      rd_seen_q    <= 1'b0;
    end else begin
      data_valid_q <= data_valid_d;
      rd_seen_q    <= rd_seen_d;
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    assign lane_we[n] = clearing | (wr_acc & ~write_mask[n]);

    ram_bank_lane #(
      .IW(IW)
    ) u_lane (
      .clk_i   (clk),
      .we_i    (lane_we[n]),
      .re_i    (rd_acc),
      .addr_i  (mem_addr),
      .wdata_i (clearing ? 8'h00 : data_in[8*n +: 8]),
      .rdata_o (rdata[8*n +: 8])
    );
  end

  // Byte-select address bits carry no meaning for a word-wide port.
  if (LB > 0) begin : g_unused_lsb
    logic unused_lsb;
    assign unused_lsb = ^address[LB-1:0];
  end

  assign data_valid = data_valid_q;
  assign data_out   = rd_seen_q ? rdata : '0;

endmodule
